regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-port arbiter and sequencer for the 32x32 register file's single write port. It merges two writeback streams onto one port. The in-order pipeline writeback always wins. The multi-cycle unit (divider, load-miss return) has its results buffered in a small in-order queue that drains on free cycles. It also gives decode a pending-write hazard query, and it kills stale queued writes that a younger pipeline write has overtaken.

## Interface
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register address width
- FIFO_DEPTH, 4, multi-cycle writeback queue entries (power of two, >= 2)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pipe_we  in  1  pipeline writeback request; no backpressure
- pipe_waddr  in  ADDR_WIDTH  pipeline destination register
- pipe_wdata  in  DATA_WIDTH  pipeline result
- mc_valid  in  1  multi-cycle result valid
- mc_ready  out  1  queue can accept; equals !full && !rst
- mc_waddr  in  ADDR_WIDTH  multi-cycle destination register
- mc_wdata  in  DATA_WIDTH  multi-cycle result
- rf_we  out  1  register file write enable (registered)
- rf_waddr  out  ADDR_WIDTH  register file write address (registered)
- rf_wdata  out  DATA_WIDTH  register file write data (registered)
- q1_addr, q2_addr  in  ADDR_WIDTH  decode source-register hazard queries
- q1_hit, q2_hit  out  1  query address has a valid queued write
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupied queue slots, killed entries included

## Operation
- Queue: circular buffer with head/tail pointers and a count. Each entry holds {valid, waddr, wdata}.
- Accept: mc_valid && mc_ready is a handshake.
  - If mc_waddr != 0, the result is pushed at the tail with valid = 1.
  - If mc_waddr == 0, the result is accepted and discarded, with no push.
- Arbitration, evaluated each cycle:
  - Pipe write: pipe_we && pipe_waddr != 0 is a pipe write. It is selected and the queue does not pop.
  - Otherwise, if count > 0, the head pops. rf_we follows the head's valid bit, so a killed entry consumes its pop cycle with rf_we = 0.
  - Otherwise there is no write.
- Kill: on a pipe write, every valid queued entry with waddr == pipe_waddr has its valid bit cleared.
  - An entry pushed in the same cycle with matching waddr is also stored with valid = 0.
  - Rule: a same-cycle pipe write is always younger than any multi-cycle result.
- Hazard query: qN_hit = (qN_addr != 0) && (some entry with valid = 1 has waddr == qN_addr). It is combinational from registered state only, so same-cycle pushes and kills are not reflected.
- pipe_we with waddr 0 counts as idle, and the queue may drain in that cycle.
- Count update: +1 on push only, −1 on pop only, unchanged on push+pop. Pointers wrap modulo FIFO_DEPTH.
- No push when full (mc_ready = 0). A same-cycle pop does not re-enable acceptance, so there is no push-through.

## Timing
- Reset (rst = 1 at an edge):
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0.
  - count = 0, pointers = 0, all valid bits = 0.
  - mc_ready = 0 while rst is high; q1_hit = q2_hit = 0 after the edge.
  - Reset mid-drain discards all queued writes.
- Pipe latency: a pipe_we sampled at edge N appears on rf_* during cycle N+1.
- Multi-cycle latency: accepted at edge N, head visible in cycle N+1, popped at edge N+1 if no pipe write, on rf_* in cycle N+2. Minimum latency is 2 cycles.
- Each rf_* write lasts exactly one cycle; rf_we deasserts the next cycle unless there is another write.
- Starvation: under back-to-back pipe writes the queue does not drain. This is acceptable; pipeline bubbles guarantee progress.

## Test plan
- Reset: hold rst 2 cycles with mc_valid = 1 and pipe_we = 1 -> rf_we = 0, fifo_count = 0, mc_ready = 0. Release -> mc_ready = 1 next cycle.
- Pipe pass-through: pipe_we = 1, waddr = 5, wdata = 0x1234 at edge N -> rf_we = 1, rf_waddr = 5, rf_wdata = 0x1234 in cycle N+1. Repeat with waddr = 0 -> rf_we = 0.
- Queue fill and drain:
  - Push 4 results (r1..r4 = 0xA1..0xA4) while pipe_we = 1 continuously -> fifo_count = 4, mc_ready = 0, a fifth mc_valid is not accepted.
  - Drop pipe_we -> r1..r4 written in order on 4 consecutive cycles, fifo_count returns to 0, pointers wrap.
- Kill:
  - Queue r7 = 0x11. Pipe writes r7 = 0x22 -> rf_wdata = 0x22 and q1_hit(7) = 0.
  - The later pop of the killed r7 entry gives rf_we = 0. The regfile ends with r7 = 0x22.
- Simultaneous push/pop at count = 2 -> count stays 2, order preserved. Push with mc_waddr = 0 -> accepted, count unchanged.
- Hazard query: queue r3 -> q1_hit = 1 with q1_addr = 3 from the cycle after acceptance until the pop edge. q2_addr = 0 -> q2_hit = 0 always.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Arbitrates the register file's single write port between the in-order
//   pipeline writeback (always wins) and a multi-cycle result stream. The
//   multi-cycle results wait in an in-order queue and drain on free cycles.
//   A pipeline write kills any queued write to the same register, because the
//   pipeline write is younger. Decode can ask whether a source register has a
//   write still pending in the queue.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   pipe_we/waddr/wdata      pipeline writeback request (no backpressure)
//   mc_valid/ready/waddr/wdata  multi-cycle result handshake
//   rf_we/waddr/wdata        registered register-file write port
//   q1_addr/q1_hit, q2_addr/q2_hit  pending-write hazard queries
//   fifo_count               occupied queue slots, killed entries included
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pipe_we,
    input  logic [ADDR_WIDTH-1:0]         pipe_waddr,
    input  logic [DATA_WIDTH-1:0]         pipe_wdata,
    input  logic                          mc_valid,
    output logic                          mc_ready,
    input  logic [ADDR_WIDTH-1:0]         mc_waddr,
    input  logic [DATA_WIDTH-1:0]         mc_wdata,
    output logic                          rf_we,
    output logic [ADDR_WIDTH-1:0]         rf_waddr,
    output logic [DATA_WIDTH-1:0]         rf_wdata,
    input  logic [ADDR_WIDTH-1:0]         q1_addr,
    input  logic [ADDR_WIDTH-1:0]         q2_addr,
    output logic                          q1_hit,
    output logic                          q2_hit,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;
    logic [FIFO_DEPTH-1:0] ent_valid;
    logic [ADDR_WIDTH-1:0] ent_waddr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] ent_wdata [FIFO_DEPTH];

    logic full;
    logic pipe_wr;
    logic push;
    logic pop;
    logic push_valid;
    logic hit1;
    logic hit2;

    // Acceptance looks only at the registered count: a pop in the same cycle
    // does not free a slot for a push (no push-through).
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign mc_ready = !full && !rst;

    // Writes to r0 are architecturally meaningless: a pipe write to r0 is an
    // idle cycle, and a multi-cycle result to r0 is accepted but not queued.
    assign pipe_wr    = pipe_we && (pipe_waddr != '0);
    assign push       = mc_valid && mc_ready && (mc_waddr != '0);
    assign pop        = !pipe_wr && (count != '0);
    // A same-cycle pipe write is younger, so a matching push is born dead.
    assign push_valid = !(pipe_wr && (mc_waddr == pipe_waddr));

    assign fifo_count = count;

    // Queue control state. Popping clears the slot's valid bit so that
    // valid implies occupied, which keeps the hazard query a plain search.
    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (pipe_wr) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (ent_waddr[i] == pipe_waddr) ent_valid[i] <= 1'b0;
                end
            end
            if (pop)  ent_valid[head] <= 1'b0;
            if (push) ent_valid[tail] <= push_valid;
        end
    end

    // Queue payload; never needs reset because valid gates every use.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_waddr[tail] <= mc_waddr;
            ent_wdata[tail] <= mc_wdata;
        end
    end

    // Write port stage: pipe write, else head pop (killed head gives rf_we=0).
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (pipe_wr) begin
            rf_we    <= 1'b1;
            rf_waddr <= pipe_waddr;
            rf_wdata <= pipe_wdata;
        end else if (pop) begin
            rf_we    <= ent_valid[head];
            rf_waddr <= ent_waddr[head];
            rf_wdata <= ent_wdata[head];
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Hazard query over registered queue state only.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_valid[i] && (ent_waddr[i] == q1_addr)) hit1 = 1'b1;
            if (ent_valid[i] && (ent_waddr[i] == q2_addr)) hit2 = 1'b1;
        end
    end

    assign q1_hit = hit1 && (q1_addr != '0);
    assign q2_hit = hit2 && (q2_addr != '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based reference model.
module tb_regfile_wb_arbiter;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_waddr;
    logic [31:0] mc_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  q1_addr;
    logic [4:0]  q2_addr;
    logic        q1_hit;
    logic        q2_hit;
    logic [2:0]  fifo_count;

    regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_waddr(mc_waddr), .mc_wdata(mc_wdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_hit(q1_hit), .q2_hit(q2_hit),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending multi-cycle writes as an ordered queue.
    typedef struct {
        logic        v;
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        e_we;
    logic        e_adv;      // address/data are defined this cycle
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] mregs  [32];
    logic [31:0] shadow [32];
    bit          chk_en = 0;

    function automatic logic mhit(input logic [4:0] a);
        logic h = 1'b0;
        if (a != 5'd0) begin
            foreach (mq[i]) if (mq[i].v && mq[i].a == a) h = 1'b1;
        end
        return h;
    endfunction

    task automatic model_step();
        ent_t e;
        bit   pw;
        bit   rdy;
        if (rst) begin
            mq.delete();
            e_we = 1'b0; e_adv = 1'b1; e_addr = 5'd0; e_data = 32'd0;
        end else begin
            rdy   = (mq.size() < DEPTH);
            pw    = pipe_we && (pipe_waddr != 5'd0);
            e_we  = 1'b0;
            e_adv = 1'b0;
            if (pw) begin
                e_we = 1'b1; e_adv = 1'b1; e_addr = pipe_waddr; e_data = pipe_wdata;
                foreach (mq[i]) if (mq[i].a == pipe_waddr) mq[i].v = 1'b0;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                e_we = e.v; e_adv = e.v;
                if (e.v) begin e_addr = e.a; e_data = e.d; end
            end
            if (mc_valid && rdy && mc_waddr != 5'd0) begin
                e.v = !(pw && mc_waddr == pipe_waddr);
                e.a = mc_waddr;
                e.d = mc_wdata;
                mq.push_back(e);
            end
            if (e_we) mregs[e_addr] = e_data;
        end
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rf_we", 32'(rf_we), 32'(e_we));
            if (e_adv) begin
                chk("rf_waddr", 32'(rf_waddr), 32'(e_addr));
                chk("rf_wdata", rf_wdata, e_data);
            end
            chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
            chk("mc_ready", 32'(mc_ready), 32'(!rst && mq.size() < DEPTH));
            chk("q1_hit", 32'(q1_hit), 32'(mhit(q1_addr)));
            chk("q2_hit", 32'(q2_hit), 32'(mhit(q2_addr)));
            if (rf_we) shadow[rf_waddr] = rf_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin mregs[i] = 32'd0; shadow[i] = 32'd0; end
        e_we = 1'b0; e_adv = 1'b0; e_addr = 5'd0; e_data = 32'd0;

        // Reset with traffic present.
        rst = 1'b1; pipe_we = 1'b1; pipe_waddr = 5'd9; pipe_wdata = 32'h99;
        mc_valid = 1'b1; mc_waddr = 5'd4; mc_wdata = 32'h44;
        q1_addr = 5'd0; q2_addr = 5'd0;
        tick();
        chk_en = 1;
        tick();
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready", 32'(mc_ready), 32'd0);
        mc_valid = 1'b0; pipe_we = 1'b0;
        rst = 1'b0;
        tick();
        chk("rel_ready", 32'(mc_ready), 32'd1);

        // Pipe pass-through, then a write to r0 as idle.
        pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'h1234;
        tick();
        chk("pipe_we", 32'(rf_we), 32'd1);
        chk("pipe_addr", 32'(rf_waddr), 32'd5);
        chk("pipe_data", rf_wdata, 32'h1234);
        pipe_waddr = 5'd0; pipe_wdata = 32'h55;
        tick();
        chk("pipe_r0_we", 32'(rf_we), 32'd0);

        // Fill the queue under continuous pipe writes.
        pipe_waddr = 5'd20; pipe_wdata = 32'h2020;
        mc_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            mc_waddr = 5'(i); mc_wdata = 32'hA0 + 32'(i);
            tick();
        end
        chk("fill_count", 32'(fifo_count), 32'd4);
        chk("fill_ready", 32'(mc_ready), 32'd0);
        mc_waddr = 5'd5; mc_wdata = 32'hA5;
        tick();
        chk("fifth_count", 32'(fifo_count), 32'd4);
        mc_valid = 1'b0; pipe_we = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("drain_we", 32'(rf_we), 32'd1);
            chk("drain_addr", 32'(rf_waddr), 32'(i));
            chk("drain_data", rf_wdata, 32'hA0 + 32'(i));
        end
        chk("drain_count", 32'(fifo_count), 32'd0);
        tick();
        chk("drain_idle", 32'(rf_we), 32'd0);

        // Kill: queued r7 overtaken by a pipe write.
        q1_addr = 5'd7;
        mc_valid = 1'b1; mc_waddr = 5'd7; mc_wdata = 32'h11;
        tick();
        mc_valid = 1'b0;
        pipe_we = 1'b1; pipe_waddr = 5'd7; pipe_wdata = 32'h22;
        #1;
        chk("kill_hit_before", 32'(q1_hit), 32'd1);
        tick();
        chk("kill_data", rf_wdata, 32'h22);
        chk("kill_hit_after", 32'(q1_hit), 32'd0);
        chk("kill_count", 32'(fifo_count), 32'd1);
        pipe_we = 1'b0;
        tick();
        chk("killed_pop_we", 32'(rf_we), 32'd0);
        chk("killed_pop_cnt", 32'(fifo_count), 32'd0);
        tick();
        chk("r7_final", shadow[7], 32'h22);
        chk("model_r7", mregs[7], 32'h22);

        // Simultaneous push and pop at count 2.
        pipe_we = 1'b1; pipe_waddr = 5'd20; pipe_wdata = 32'h77;
        mc_valid = 1'b1; mc_waddr = 5'd10; mc_wdata = 32'hB0;
        tick();
        mc_waddr = 5'd11; mc_wdata = 32'hB1;
        tick();
        chk("pp_count2", 32'(fifo_count), 32'd2);
        pipe_we = 1'b0;
        mc_waddr = 5'd12; mc_wdata = 32'hB2;
        tick();
        chk("pp_count", 32'(fifo_count), 32'd2);
        chk("pp_addr", 32'(rf_waddr), 32'd10);
        mc_valid = 1'b0;
        tick();
        chk("pp_order1", rf_wdata, 32'hB1);
        tick();
        chk("pp_order2", rf_wdata, 32'hB2);
        mc_valid = 1'b1; mc_waddr = 5'd0; mc_wdata = 32'hCC;
        #1;
        chk("r0_ready", 32'(mc_ready), 32'd1);
        tick();
        chk("r0_count", 32'(fifo_count), 32'd0);
        mc_valid = 1'b0;

        // Hazard query lifetime.
        q1_addr = 5'd3; q2_addr = 5'd0;
        pipe_we = 1'b1; pipe_waddr = 5'd20;
        mc_valid = 1'b1; mc_waddr = 5'd3; mc_wdata = 32'h33;
        #1;
        chk("hz_before", 32'(q1_hit), 32'd0);
        tick();
        mc_valid = 1'b0;
        #1;
        chk("hz_q1", 32'(q1_hit), 32'd1);
        chk("hz_q2", 32'(q2_hit), 32'd0);
        tick();
        chk("hz_hold", 32'(q1_hit), 32'd1);
        pipe_we = 1'b0;
        tick();
        chk("hz_popped", 32'(q1_hit), 32'd0);
        chk("hz_addr", 32'(rf_waddr), 32'd3);

        // Randomized traffic with small address range to provoke kills.
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            pipe_we    = ($urandom_range(0, 99) < ((c / 300) % 2 == 0 ? 30 : 70));
            pipe_waddr = 5'($urandom_range(0, 7));
            pipe_wdata = $urandom;
            mc_valid   = ($urandom_range(0, 1) == 1);
            mc_waddr   = 5'($urandom_range(0, 7));
            mc_wdata   = $urandom;
            q1_addr    = 5'($urandom_range(0, 7));
            q2_addr    = 5'($urandom_range(0, 7));
            tick();
        end
        rst = 1'b0; pipe_we = 1'b0; mc_valid = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        chk("end_count", 32'(fifo_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
